// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: register-index type, architectural
// register numbers and the stack pointer reset value. The register-destination
// select logic uses the same types.
package cpu_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam int       NUM_REGS     = 32;
  localparam reg_idx_t REG_ZERO     = 5'd0;
  localparam reg_idx_t REG_SP       = 5'd29;
  localparam reg_idx_t REG_RA       = 5'd31;
  localparam int       SP_RESET_VAL = 227;

  // A write strobe only changes storage when it targets a register other than $0.
  function automatic logic wr_commits(input logic we, input reg_idx_t idx);
    return we && (idx != REG_ZERO);
  endfunction

endpackage : cpu_pkg

// File: rtl/reg_bank_rport.sv
// Single combinational read port of the write-back register bank.
// Index 0 always reads zero. With REG_BYPASS_EN defined, a same-cycle write
// to the addressed register is forwarded (write-first); otherwise the port
// returns stored contents only (read-before-write).
module reg_bank_rport
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] regs_i [NUM_REGS],
  input  reg_idx_t          rd_idx,
  input  logic              wr_en,
  input  reg_idx_t          wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

`ifdef REG_BYPASS_EN
  // Stored value, overridden by an in-flight write to the same non-zero index.
  always_comb begin
    rd_data = '0;
    if (rd_idx != REG_ZERO) begin
      rd_data = regs_i[rd_idx];
      if (wr_commits(wr_en, wr_idx) && (wr_idx == rd_idx)) begin
        rd_data = wr_data;
      end
    end
  end
`else
  // Write-side inputs are only needed for forwarding.
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_idx, wr_data};

  // Stored value; $0 is forced to zero regardless of storage.
  always_comb begin
    rd_data = '0;
    if (rd_idx != REG_ZERO) begin
      rd_data = regs_i[rd_idx];
    end
  end
`endif

endmodule : reg_bank_rport

// File: rtl/reg_bank_wb.sv
// Write-back register bank: 32 registers, two combinational read ports,
// $0 write protection, stack-pointer reset value, a registered write-completion
// pulse and a sticky "return address written" flag.
// Optional feature macro: REG_BYPASS_EN (same-cycle write-to-read forwarding).
module reg_bank_wb
  import cpu_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              SP_IDX   = int'(REG_SP),
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_VAL),
  parameter int              RA_IDX   = int'(REG_RA)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              wr_done,
  output logic [4:0]        wr_done_idx,
  output logic              ra_written
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_done_q,     wr_done_d;
  reg_idx_t          wr_done_idx_q, wr_done_idx_d;
  logic              ra_written_q,  ra_written_d;
  logic              commit;

  assign commit = wr_commits(reg_write, write_reg);

  // Next register contents: a committing write replaces one entry.
  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      regs_d[write_reg] = write_data;
    end
  end

  // Completion report: every strobe (including dropped $0 writes) is acknowledged.
  always_comb begin
    wr_done_d     = reg_write;
    wr_done_idx_d = reg_write ? write_reg : REG_ZERO;
    ra_written_d  = ra_written_q;
    if (commit && (write_reg == reg_idx_t'(RA_IDX))) begin
      ra_written_d = 1'b1;
    end
  end

  // Register storage; reset loads zero everywhere except the stack pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Status flops for the control unit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_done_q     <= 1'b0;
      wr_done_idx_q <= REG_ZERO;
      ra_written_q  <= 1'b0;
    end else begin
      wr_done_q     <= wr_done_d;
      wr_done_idx_q <= wr_done_idx_d;
      ra_written_q  <= ra_written_d;
    end
  end

  assign wr_done     = wr_done_q;
  assign wr_done_idx = wr_done_idx_q;
  assign ra_written  = ra_written_q;

  reg_bank_rport #(.DATA_W(DATA_W)) u_rport1 (
    .regs_i  (regs_q),
    .rd_idx  (read_reg1),
    .wr_en   (reg_write),
    .wr_idx  (write_reg),
    .wr_data (write_data),
    .rd_data (read_data1)
  );

  reg_bank_rport #(.DATA_W(DATA_W)) u_rport2 (
    .regs_i  (regs_q),
    .rd_idx  (read_reg2),
    .wr_en   (reg_write),
    .wr_idx  (write_reg),
    .wr_data (write_data),
    .rd_data (read_data2)
  );

endmodule : reg_bank_wb

// File: tb/tb_reg_bank_wb.sv
// Directed bench for reg_bank_wb; expected values are hand-computed constants.
module tb_reg_bank_wb;

  logic        clk;
  logic        clk_en;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        wr_done;
  logic [4:0]  wr_done_idx;
  logic        ra_written;

  int n_cmp;
  int n_err;

  reg_bank_wb dut (
    .clk         (clk),
    .reset       (reset),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .read_reg1   (read_reg1),
    .read_reg2   (read_reg2),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .wr_done     (wr_done),
    .wr_done_idx (wr_done_idx),
    .ra_written  (ra_written)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_rst;
  logic [31:0] exp_pre5;
  logic [31:0] exp_pre8;

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk = 1'b0;
    clk_en = 1'b0;
    reset = 1'b0;
    reg_write = 1'b0;
    write_reg = 5'd0;
    write_data = 32'h0;
    read_reg1 = 5'd0;
    read_reg2 = 5'd0;

    // Reset with no clock running: must take effect asynchronously.
    #2 reset = 1'b1;
    #2;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      #1;
      exp_rst = (i == 29) ? 32'd227 : 32'd0;
      check_val($sformatf("rst_rd1[%0d]", i), read_data1, exp_rst);
      exp_rst = ((31 - i) == 29) ? 32'd227 : 32'd0;
      check_val($sformatf("rst_rd2[%0d]", 31 - i), read_data2, exp_rst);
    end
    check_val("rst_wr_done", {31'd0, wr_done}, 32'd0);
    check_val("rst_wr_done_idx", {27'd0, wr_done_idx}, 32'd0);
    check_val("rst_ra_written", {31'd0, ra_written}, 32'd0);

    reset = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);

    // Basic write to index 8.
`ifdef REG_BYPASS_EN
    exp_pre8 = 32'hDEADBEEF;
`else
    exp_pre8 = 32'h0;
`endif
    reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEADBEEF;
    read_reg1 = 5'd8; read_reg2 = 5'd8;
    #1;
    check_val("w8_pre_rd1", read_data1, exp_pre8);
    @(posedge clk); #1;
    check_val("w8_post_rd1", read_data1, 32'hDEADBEEF);
    check_val("w8_wr_done", {31'd0, wr_done}, 32'd1);
    check_val("w8_wr_done_idx", {27'd0, wr_done_idx}, 32'd8);
    @(negedge clk);
    reg_write = 1'b0;
    @(posedge clk); #1;
    check_val("idle_wr_done", {31'd0, wr_done}, 32'd0);
    check_val("w8_hold", read_data2, 32'hDEADBEEF);

    // $0 write is dropped but still acknowledged; never bypassed.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h12345678;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    #1;
    check_val("z_pre_rd1", read_data1, 32'h0);
    check_val("z_pre_rd2", read_data2, 32'h0);
    @(posedge clk); #1;
    check_val("z_post_rd1", read_data1, 32'h0);
    check_val("z_post_rd2", read_data2, 32'h0);
    check_val("z_wr_done", {31'd0, wr_done}, 32'd1);
    check_val("z_wr_done_idx", {27'd0, wr_done_idx}, 32'd0);
    check_val("z_ra_written", {31'd0, ra_written}, 32'd0);

    // Back-to-back writes: RA then SP.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h00000040;
    read_reg1 = 5'd31; read_reg2 = 5'd29;
    @(posedge clk); #1;
    check_val("ra_wr_done", {31'd0, wr_done}, 32'd1);
    check_val("ra_wr_done_idx", {27'd0, wr_done_idx}, 32'd31);
    check_val("ra_flag", {31'd0, ra_written}, 32'd1);
    check_val("ra_rd1", read_data1, 32'h00000040);
    check_val("sp_before", read_data2, 32'd227);
    @(negedge clk);
    write_reg = 5'd29; write_data = 32'h000000E3;
    @(posedge clk); #1;
    check_val("sp_wr_done", {31'd0, wr_done}, 32'd1);
    check_val("sp_wr_done_idx", {27'd0, wr_done_idx}, 32'd29);
    check_val("sp_rd2", read_data2, 32'h000000E3);
    check_val("ra_rd1_b", read_data1, 32'h00000040);
    @(negedge clk);
    reg_write = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("ra_sticky", {31'd0, ra_written}, 32'd1);
    check_val("b2b_idle_done", {31'd0, wr_done}, 32'd0);

    // Same-cycle read/write on index 5, after seeding an old value.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'h11112222;
    @(posedge clk);
    @(negedge clk);
`ifdef REG_BYPASS_EN
    exp_pre5 = 32'hA5A5A5A5;
`else
    exp_pre5 = 32'h11112222;
`endif
    write_data = 32'hA5A5A5A5;
    read_reg1 = 5'd5; read_reg2 = 5'd5;
    #1;
    check_val("rw5_pre_rd2", read_data2, exp_pre5);
    check_val("rw5_pre_rd1", read_data1, exp_pre5);
    @(posedge clk); #1;
    check_val("rw5_post_rd2", read_data2, 32'hA5A5A5A5);
    check_val("rw5_post_rd1", read_data1, 32'hA5A5A5A5);
    check_val("rw5_wr_done_idx", {27'd0, wr_done_idx}, 32'd5);
    @(negedge clk);
    reg_write = 1'b0;
    read_reg1 = 5'd8;
    #1;
    check_val("r8_untouched", read_data1, 32'hDEADBEEF);

    // Seed index 10, then reset concurrently with a write to it.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd10; write_data = 32'h00000077;
    @(posedge clk);
    @(negedge clk);
    write_data = 32'h00000099;
    reset = 1'b1;
    read_reg1 = 5'd10; read_reg2 = 5'd29;
    #1;
    check_val("mr_rd10_async", read_data1, 32'h0);
    check_val("mr_rd29_async", read_data2, 32'd227);
    check_val("mr_wr_done_async", {31'd0, wr_done}, 32'd0);
    check_val("mr_ra_cleared", {31'd0, ra_written}, 32'd0);
    @(posedge clk); #1;
    check_val("mr_rd10_edge", read_data1, 32'h0);
    check_val("mr_wr_done_edge", {31'd0, wr_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    reg_write = 1'b0;
    @(posedge clk); #1;
    check_val("mr_wr_done_after", {31'd0, wr_done}, 32'd0);
    check_val("mr_rd10_after", read_data1, 32'h0);
    check_val("mr_rd29_after", read_data2, 32'd227);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_reg_bank_wb

// File: doc/reg_bank_wb.md
Name: reg_bank_wb

Overview:
- Register file at the write-back end of the multicycle datapath.
- Consumes the 5-bit destination index from the register-destination select path (rt, rd, 31/ra or 29/sp) together with the write-back data.
- Provides two combinational read ports to the operand latches (A/B).
- Owns register reset values, the $0 write protection, and a registered write-completion report for the control unit.

Parameters:
- DATA_W, 32, register width in bits
- SP_IDX, 29, index of the stack pointer register
- SP_RESET, 227, reset value of the stack pointer register
- RA_IDX, 31, index of the return address register (used only for reporting)

Ports:
- clk  input  1  system clock, rising edge active
- reset  input  1  asynchronous, active-high reset
- reg_write  input  1  write strobe, sampled on rising clk
- write_reg  input  5  destination index from the register-destination select
- write_data  input  DATA_W  write-back value
- read_reg1  input  5  read port 1 index (inst[25:21])
- read_reg2  input  5  read port 2 index (inst[20:16])
- read_data1  output  DATA_W  read port 1 data, combinational
- read_data2  output  DATA_W  read port 2 data, combinational
- wr_done  output  1  one-cycle pulse: a write committed on the previous edge
- wr_done_idx  output  5  index committed, valid while wr_done=1
- ra_written  output  1  sticky flag: RA_IDX has been written since reset

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high, named clk and reset.
- On reset assertion, immediately and without waiting for a clock edge:
  - all 32 registers go to 0, except SP_IDX which goes to SP_RESET;
  - wr_done=0, wr_done_idx=0, ra_written=0.
- Write commit: on a rising clk with reg_write=1, reset=0 and write_reg!=0, register[write_reg] <= write_data.
- Register $0:
  - writes to index 0 are dropped and storage stays 0;
  - the drop still generates wr_done=1 with wr_done_idx=0, so the control unit sees completion.
- wr_done timing:
  - registered; it is 1 in the cycle after each edge where reg_write=1, otherwise 0;
  - back-to-back writes hold wr_done high on consecutive cycles, with wr_done_idx tracking each index.
- ra_written: set on commit of index RA_IDX and cleared only by reset.
- Reads:
  - read_dataN = register[read_regN], purely combinational;
  - index 0 always reads 0;
  - both ports may address the same register and the same value is returned on both.
- Read during write, same index, same cycle, without the bypass feature:
  - the read returns the old value until the edge and the new value after it.
- Reset mid-write: if reset is asserted in the same cycle as reg_write, reset wins and no write occurs.
- write_reg values: any 5-bit value is legal and there is no out-of-range case. Indices 29 and 31 behave as ordinary registers except for their reset value and reporting.
- Latency:
  - write: 1 edge;
  - wr_done: 1 cycle after the commit edge;
  - read: 0 cycles.

Optional Feature:
- Macro REG_BYPASS_EN.
- Defined: when reg_write=1, write_reg!=0 and read_regN==write_reg, read_dataN returns write_data in the same cycle (write-first forwarding). Index 0 is never bypassed.
- Undefined: reads always return stored contents, giving read-before-write behaviour.

Decomposition:
- Shared package cpu_pkg holds:
  - constants REG_ZERO=0, REG_SP=29, REG_RA=31, SP_RESET_VAL=227;
  - a 5-bit reg_idx_t typedef, also used by the register-destination select logic.
- One natural sub-module, reg_bank_rport: a single combinational read port containing the index-0 check and the optional bypass. It is instantiated twice.

Test Plan:
- Reset check: assert reset with no clock, then read all 32 indices -> 0 everywhere except index 29 = 227; wr_done=0, ra_written=0.
- Basic write: write_reg=8, write_data=0xDEADBEEF, reg_write=1 for one edge -> read_reg1=8 gives 0xDEADBEEF after the edge; next cycle wr_done=1, wr_done_idx=8.
- $0 protection: write 0x12345678 to index 0 -> read_data1/2 stay 0 at index 0; wr_done=1 with wr_done_idx=0.
- Return address: write index 31 = 0x00000040, then write index 29 = 0x000000E3 -> reads return 0x40 and 0xE3; ra_written=1 and stays 1 until reset.
- Same-cycle read/write: read_reg2=5 while writing 0xA5A5A5A5 to index 5 -> before the edge read_data2 shows the old value, or 0xA5A5A5A5 with REG_BYPASS_EN; after the edge it shows 0xA5A5A5A5 in both builds.
- Reset mid-operation: assert reset concurrently with reg_write=1 on index 10 -> index 10 reads 0, index 29 reads 227, and no wr_done pulse follows.
